// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the response mux and the default slave.
// Holds the HTRANS/HRESP encodings, the data-phase owner enum and the
// default-slave state enum. It also holds the address-phase owner decode.
package ahb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned HTRANS_W = 2;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Data-phase owner held in sel_q
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_G    = 3'd1,
        SEL_T    = 3'd2,
        SEL_R    = 3'd3,
        SEL_DEF  = 3'd4
    } sel_e;

    // Default-slave two-cycle ERROR sequencer
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // Address-phase owner: G > T > R, otherwise DEF for an active transfer
    function automatic sel_e decode_sel(input logic hsel_g,
                                        input logic hsel_t,
                                        input logic hsel_r,
                                        input logic [HTRANS_W-1:0] htrans);
        sel_e res;
        if (hsel_g)                                              res = SEL_G;
        else if (hsel_t)                                         res = SEL_T;
        else if (hsel_r)                                         res = SEL_R;
        else if (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) res = SEL_DEF;
        else                                                     res = SEL_NONE;
        return res;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default (unmapped) slave: answers every transfer it owns with the
// two-cycle AHB ERROR response.
// Ports: HCLK/HRESET (sync active-high), HSEL_DEF (address-phase select of
// the default slave), HREADY_IN (bus HREADY), HREADYOUT/HRESP (data phase).
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic HSEL_DEF,
    input  logic HREADY_IN,
    output logic HREADYOUT,
    output logic HRESP
);

    ds_state_e state_q;
    ds_state_e state_d;

    // A new transfer is accepted only on a bus-ready edge
    logic accept;
    assign accept = HSEL_DEF && HREADY_IN;

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= DS_IDLE;
        else        state_q <= state_d;
    end

    // Next state and data-phase outputs
    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (accept) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP   = HRESP_ERROR;
                // A back-to-back unmapped transfer restarts the sequence
                state_d = accept ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave response multiplexer for the GPIO, Timer and RCC slaves
// plus a built-in default slave for unmapped addresses.
// Ports: HCLK/HRESET (sync active-high), HSEL_G/T/R + HTRANS (address phase),
// HRDATA_x/HREADYOUT_x/HRESP_x (slave data phase), HRDATA/HREADY/HRESP
// (muxed to the master; HREADY is also the slaves' HREADY input).
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = 32'h0000_0000
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL_G,
    input  logic                HSEL_T,
    input  logic                HSEL_R,
    input  logic [HTRANS_W-1:0] HTRANS,
    input  logic [DATA_W-1:0]   HRDATA_G,
    input  logic [DATA_W-1:0]   HRDATA_T,
    input  logic [DATA_W-1:0]   HRDATA_R,
    input  logic                HREADYOUT_G,
    input  logic                HREADYOUT_T,
    input  logic                HREADYOUT_R,
    input  logic                HRESP_G,
    input  logic                HRESP_T,
    input  logic                HRESP_R,
    output logic [DATA_W-1:0]   HRDATA,
    output logic                HREADY,
    output logic                HRESP
);

    sel_e sel_q;
    sel_e sel_d;
    sel_e addr_sel;
    logic def_hreadyout;
    logic def_hresp;

    assign addr_sel = decode_sel(HSEL_G, HSEL_T, HSEL_R, HTRANS);

    // Owner advances only when the current data phase completes
    always_comb begin
        sel_d = sel_q;
        if (HREADY) sel_d = addr_sel;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) sel_q <= SEL_NONE;
        else        sel_q <= sel_d;
    end

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL_DEF  (addr_sel == SEL_DEF),
        .HREADY_IN (HREADY),
        .HREADYOUT (def_hreadyout),
        .HRESP     (def_hresp)
    );

    // Response mux, driven only by registered owner and slave outputs
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        case (sel_q)
            SEL_G: begin
                HRDATA = HRDATA_G;
                HREADY = HREADYOUT_G;
                HRESP  = HRESP_G;
            end
            SEL_T: begin
                HRDATA = HRDATA_T;
                HREADY = HREADYOUT_T;
                HRESP  = HRESP_T;
            end
            SEL_R: begin
                HRDATA = HRDATA_R;
                HREADY = HREADYOUT_R;
                HRESP  = HRESP_R;
            end
            SEL_DEF: begin
                HRDATA = DEFAULT_RDATA;
                HREADY = def_hreadyout;
                HRESP  = def_hresp;
            end
            default: begin
                HRDATA = '0;
                HREADY = 1'b1;
                HRESP  = HRESP_OKAY;
            end
        endcase
    end

endmodule
